ones_accumulator: RTL
=====================

ONES_ACCUMULATOR -- requirements
Module: ones_accumulator

Interface
REQ-001 Parameter MAX_BYTES, default 256, is the maximum accepted beats per frame.
REQ-002 Parameter SUM_W, default 12, is the result width; the minimum legal value is clog2(8*MAX_BYTES+1).
REQ-003 Parameter LEN_W, default 9, is the beat-count width; the minimum legal value is clog2(MAX_BYTES+1).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cnt_in  input  4  per-byte ones count from the upstream popcount stage; legal range is 0..8.
REQ-007 cnt_valid  input  1  cnt_in is valid this cycle.
REQ-008 cnt_last  input  1  the beat is the final beat of the frame; qualified by cnt_valid.
REQ-009 cnt_ready  output  1  the block accepts a beat this cycle.
REQ-010 sum_out  output  SUM_W  total ones in the completed frame.
REQ-011 len_out  output  LEN_W  number of beats accepted in the completed frame.
REQ-012 err_out  output  1  frame had an illegal cnt_in (>8) or exceeded MAX_BYTES.
REQ-013 out_valid  output  1  sum_out, len_out and err_out are valid.
REQ-014 out_ready  input  1  downstream accepts the result.

Function
REQ-015 A beat SHALL be accepted only in a cycle where cnt_valid=1 and cnt_ready=1.
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-017 IDLE SHALL drive cnt_ready=1 and out_valid=0; an accepted beat without last SHALL move the FSM to ACCUM, and an accepted beat with last SHALL move it to DONE.
REQ-018 ACCUM SHALL drive cnt_ready=1; an accepted beat with last SHALL move the FSM to DONE, and the FSM SHALL otherwise stay in ACCUM.
REQ-019 DONE SHALL drive cnt_ready=0 and out_valid=1; out_valid=1 with out_ready=1 SHALL move the FSM to IDLE.
REQ-020 Each accepted beat SHALL add cnt_in (zero-extended) to the running sum and increment the running length by 1.
REQ-021 The first beat of a frame SHALL load the running sum with cnt_in and the running length with 1, with no carry-over from the previous frame.
REQ-022 The result SHALL become valid on the cycle after the last beat is accepted (latency 1), and the result SHALL include the last beat.
REQ-023 sum_out, len_out and err_out SHALL be registered and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 cnt_in > 8 on an accepted beat SHALL set the sticky frame error; that beat SHALL add 8 to the running sum.
REQ-025 A beat accepted when the running length equals MAX_BYTES SHALL set the sticky error and SHALL NOT change the running sum or length; the frame still closes on last.
REQ-026 The running sum SHALL saturate at all-ones and SHALL never wrap around.
REQ-027 The sticky error SHALL clear at the start of the next frame.
REQ-028 cnt_valid=0 cycles inside a frame SHALL hold all state.
REQ-029 cnt_last without cnt_valid SHALL be ignored.
REQ-030 In DONE the block SHALL not accept back-to-back input; upstream stalls for at least one cycle per frame.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, cnt_ready=1, out_valid=0, sum_out=0, len_out=0, err_out=0, running sum 0, running length 0 and error 0.
REQ-032 Reset SHALL take priority over any simultaneous handshake.
REQ-033 A frame in progress when reset is applied SHALL be discarded, and no result for it SHALL be emitted.

Structure
REQ-034 Package ones_acc_pkg SHALL hold the state enum (IDLE, ACCUM, DONE), the MAX_CNT=8 constant and the default widths.
REQ-035 Sub-module sat_add SHALL implement the SUM_W saturating adder with 4-bit addend; all other logic is flat in ones_accumulator.
REQ-036 ones_accumulator SHALL attach directly to the popcount stage output (cnt_in = its cnt_out) with no glue logic.

Verification
REQ-037 Frame of counts 3,5,8,0 with last on beat 4 and out_ready=1 -> out_valid one cycle after beat 4, with sum_out=16, len_out=4 and err_out=0.
REQ-038 Single beat cnt_in=7 with last -> sum_out=7, len_out=1, err_out=0; next frame 2,2 -> sum_out=4 (no carry-over).
REQ-039 out_ready held 0 for 5 cycles after a result -> result stable, cnt_ready=0 throughout; input resumes the cycle after out_ready=1.
REQ-040 cnt_in=12 on one beat of frame 1,12,last 1 -> sum_out=10, len_out=3, err_out=1; next clean frame -> err_out=0.
REQ-041 MAX_BYTES=4, frame of 6 beats of 8 -> sum_out=32, len_out=4, err_out=1.
REQ-042 rst pulsed mid-frame after beats 4,4, then frame 1 with last -> only one result emitted, sum_out=1, len_out=1.

Source files
------------

// File: rtl/ones_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ones_acc_pkg
// Description : Shared types and constants for the ones accumulator: the
//               frame FSM state encoding, the largest legal per-byte ones
//               count, and the default parameter widths.
// Revision    : 1.0  - initial release
// ============================================================================
package ones_acc_pkg;

    // Largest ones count a single byte can produce.
    localparam int MAX_CNT = 8;

    // Default widths: SUM_W >= clog2(8*MAX_BYTES+1), LEN_W >= clog2(MAX_BYTES+1).
    localparam int DEF_MAX_BYTES = 256;
    localparam int DEF_SUM_W     = 12;
    localparam int DEF_LEN_W     = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ones_accumulator_sat_add.sv
`default_nettype none
// ============================================================================
// Module      : sat_add
// Description : SUM_W-bit unsigned adder with a 4-bit addend that clamps to
//               all-ones instead of wrapping.
// Ports       : i_a   [SUM_W-1:0]  running value
//               i_b   [3:0]        addend (zero-extended)
//               o_sum [SUM_W-1:0]  saturated sum
// Revision    : 1.0  - initial release
// ============================================================================
module sat_add
    import ones_acc_pkg::*;
#(
    parameter int SUM_W = DEF_SUM_W
) (
    input  logic [SUM_W-1:0] i_a,
    input  logic [3:0]       i_b,
    output logic [SUM_W-1:0] o_sum
);

    // One extra bit catches the carry out; SUM_W must be at least 4.
    logic [SUM_W:0] w_wide;

    assign w_wide = {1'b0, i_a} + {{(SUM_W - 3){1'b0}}, i_b};
    assign o_sum  = w_wide[SUM_W] ? {SUM_W{1'b1}} : w_wide[SUM_W-1:0];

endmodule
`default_nettype wire

// File: rtl/ones_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : ones_accumulator
// Description : Sums per-byte ones counts over a frame of beats and presents
//               the total, beat count and an error flag once the frame closes.
// Ports       : clk, rst                 clock, synchronous active-high reset
//               cnt_in[3:0]              per-byte ones count (legal 0..8)
//               cnt_valid / cnt_ready    input beat handshake
//               cnt_last                 final beat of the frame
//               sum_out[SUM_W-1:0]       total ones of the completed frame
//               len_out[LEN_W-1:0]       beats accepted in the completed frame
//               err_out                  illegal count or overlong frame
//               out_valid / out_ready    result handshake
// Revision    : 1.0  - initial release
// ============================================================================
module ones_accumulator
    import ones_acc_pkg::*;
#(
    parameter int MAX_BYTES = DEF_MAX_BYTES,
    parameter int SUM_W     = DEF_SUM_W,
    parameter int LEN_W     = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       cnt_in,
    input  logic             cnt_valid,
    input  logic             cnt_last,
    output logic             cnt_ready,
    output logic [SUM_W-1:0] sum_out,
    output logic [LEN_W-1:0] len_out,
    output logic             err_out,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_BYTES);
    localparam logic [3:0]       c_max_cnt = 4'(MAX_CNT);

    state_t           r_state;
    state_t           w_state_next;

    logic [SUM_W-1:0] r_run_sum;
    logic [LEN_W-1:0] r_run_len;
    logic             r_run_err;
    logic [SUM_W-1:0] r_sum_out;
    logic [LEN_W-1:0] r_len_out;
    logic             r_err_out;

    logic             w_accept;
    logic             w_first;
    logic             w_illegal;
    logic             w_full;
    logic [3:0]       w_addend;
    logic [SUM_W-1:0] w_base_sum;
    logic [SUM_W-1:0] w_add_sum;
    logic [SUM_W-1:0] w_next_sum;
    logic [LEN_W-1:0] w_next_len;
    logic             w_next_err;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = cnt_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept && cnt_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (input is refused while a result is pending)
    // ------------------------------------------------------------------
    always_comb begin
        cnt_ready = 1'b1;
        out_valid = 1'b0;
        if (r_state == DONE) begin
            cnt_ready = 1'b0;
            out_valid = 1'b1;
        end
    end

    assign w_accept = cnt_valid & cnt_ready;

    // ------------------------------------------------------------------
    // Beat datapath
    // ------------------------------------------------------------------
    // In IDLE the next accepted beat starts a frame, so the running values
    // are replaced rather than accumulated.
    assign w_first    = (r_state == IDLE);
    assign w_illegal  = (cnt_in > c_max_cnt);
    assign w_addend   = w_illegal ? c_max_cnt : cnt_in;
    assign w_base_sum = w_first ? '0 : r_run_sum;
    // A beat beyond MAX_BYTES is flagged but contributes nothing.
    assign w_full     = !w_first && (r_run_len == c_max_len);

    sat_add #(
        .SUM_W (SUM_W)
    ) u_sat_add (
        .i_a   (w_base_sum),
        .i_b   (w_addend),
        .o_sum (w_add_sum)
    );

    assign w_next_sum = w_full ? r_run_sum : w_add_sum;
    assign w_next_len = w_first ? LEN_W'(1)
                      : (w_full ? r_run_len : r_run_len + LEN_W'(1));
    assign w_next_err = (!w_first && r_run_err) | w_illegal | w_full;

    // The result registers capture the post-last-beat totals, so they are
    // valid together with the move into DONE and hold until the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_sum <= '0;
            r_run_len <= '0;
            r_run_err <= 1'b0;
            r_sum_out <= '0;
            r_len_out <= '0;
            r_err_out <= 1'b0;
        end else if (w_accept) begin
            r_run_sum <= w_next_sum;
            r_run_len <= w_next_len;
            r_run_err <= w_next_err;
            if (cnt_last) begin
                r_sum_out <= w_next_sum;
                r_len_out <= w_next_len;
                r_err_out <= w_next_err;
            end
        end
    end

    assign sum_out = r_sum_out;
    assign len_out = r_len_out;
    assign err_out = r_err_out;

endmodule
`default_nettype wire
